// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and counter-width helper.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } pll_seq_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous clear; output is the last stage.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the pixel-clock PLL reset from the reference clock and releases sys_rst after stable lock.
// Optional: define PLL_LOSS_COUNTER_EN to add the saturating 8-bit loss_count output.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                               inclk0,
  input  logic                               areset,
  input  logic                               pll_locked,
  input  logic                               retry,
  output logic                               pll_areset,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
`ifdef PLL_LOSS_COUNTER_EN
  output logic [7:0]                         loss_count,
`endif
  output logic [STATE_W-1:0]                 state_dbg
);

  localparam int RST_W  = cnt_w(RESET_CYCLES);
  localparam int TMR_W  = cnt_w(LOCK_TIMEOUT);
  localparam int STAB_W = cnt_w(STABLE_CYCLES);
  localparam int RC_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]   RC_MAX    = RC_W'(MAX_RETRIES);

  pll_seq_state_t    state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [RC_W-1:0]   rc_inc;
  logic              timeout;
  logic              locked_s;
  logic              pll_areset_q, sys_rst_q, ready_q, fault_q;

  sync_bit #(
    .N (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (inclk0),
    .rst_i (areset),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmr_d     = tmr_q;
    stab_d    = stab_q;
    rc_d      = rc_q;
    rc_inc    = rc_q + RC_W'(1);
    timeout   = (tmr_q == TMR_LAST);

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_WAIT;
          rst_cnt_d = '0;
          tmr_d     = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      S_WAIT: begin
        tmr_d = timeout ? '0 : tmr_q + TMR_W'(1);
        if (timeout) begin
          rc_d      = rc_inc;
          state_d   = (rc_inc == RC_MAX) ? S_FAULT : S_RESET;
          rst_cnt_d = '0;
        end else if (locked_s) begin
          state_d = S_STABLE;
          stab_d  = '0;
        end
      end

      // Timer keeps running here so a flapping lock cannot stretch the attempt;
      // completing stability on the timeout cycle still counts as success.
      S_STABLE: begin
        tmr_d = timeout ? '0 : tmr_q + TMR_W'(1);
        if (locked_s && (stab_q == STAB_LAST)) begin
          state_d = S_RUN;
          rc_d    = '0;
          stab_d  = '0;
        end else if (timeout) begin
          rc_d      = rc_inc;
          state_d   = (rc_inc == RC_MAX) ? S_FAULT : S_RESET;
          rst_cnt_d = '0;
        end else if (!locked_s) begin
          state_d = S_WAIT;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end

      S_RUN: begin
        if (!locked_s) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
        end
      end

      S_FAULT: begin
        if (retry) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          rc_d      = '0;
        end
      end

      default: begin
        state_d   = S_RESET;
        rst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      state_q   <= S_RESET;
      rst_cnt_q <= '0;
      tmr_q     <= '0;
      stab_q    <= '0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      tmr_q     <= tmr_d;
      stab_q    <= stab_d;
      rc_q      <= rc_d;
    end
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      pll_areset_q <= 1'b1;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pll_areset_q <= (state_d == S_RESET) || (state_d == S_FAULT);
      sys_rst_q    <= (state_d != S_RUN);
      ready_q      <= (state_d == S_RUN);
      fault_q      <= (state_d == S_FAULT);
    end
  end

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_q;

  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      loss_q <= '0;
    end else if ((state_q == S_RUN) && (state_d == S_RESET) && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_count = loss_q;
`endif

  assign pll_areset  = pll_areset_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = rc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters; expectations queued, then popped on compare.
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int SS = 2;

  logic       inclk0 = 1'b0;
  logic       areset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       retry = 1'b0;
  logic       pll_areset, sys_rst, ready, fault;
  logic [1:0] retry_count;
  logic [2:0] state_dbg;
`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_count;
`endif

  int checks = 0;
  int errors = 0;
  string tag_q[$];
  int    exp_q[$];

  pll_reset_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .SYNC_STAGES  (SS)
  ) dut (
    .inclk0     (inclk0),
    .areset     (areset),
    .pll_locked (pll_locked),
    .retry      (retry),
    .pll_areset (pll_areset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
`ifdef PLL_LOSS_COUNTER_EN
    .loss_count (loss_count),
`endif
    .state_dbg  (state_dbg)
  );

  always #10 inclk0 = ~inclk0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input string tag, input int val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check_v(input int obs);
    string tag;
    int    expv;
    if (exp_q.size() == 0) begin
      tag  = "scoreboard_empty";
      expv = -999;
    end else begin
      tag  = tag_q.pop_front();
      expv = exp_q.pop_front();
    end
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge inclk0);
  endtask

  // sel: 0 sys_rst, 1 pll_areset, 2 state_dbg, 3 retry_count, 4 ready. n=-1 if bound expires.
  task automatic wait_sig(input int sel, input int val, input int bound, output int n);
    int cur;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge inclk0);
      case (sel)
        0:       cur = int'(sys_rst);
        1:       cur = int'(pll_areset);
        2:       cur = int'(state_dbg);
        3:       cur = int'(retry_count);
        default: cur = int'(ready);
      endcase
      if (cur == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic restart(input logic lock);
    @(negedge inclk0);
    areset     = 1'b1;
    pll_locked = lock;
    edges(2);
    areset = 1'b0;
  endtask

  initial begin
    int n, m;
    pll_locked = 1'b1;
    edges(3);

    // Reset state
    expect_v("rst_state", 0);      check_v(int'(state_dbg));
    expect_v("rst_pll_areset", 1); check_v(int'(pll_areset));
    expect_v("rst_sys_rst", 1);    check_v(int'(sys_rst));
    expect_v("rst_ready", 0);      check_v(int'(ready));
    expect_v("rst_fault", 0);      check_v(int'(fault));
    expect_v("rst_retry_count", 0); check_v(int'(retry_count));

    // 1. Clean lock
    areset = 1'b0;
    expect_v("t1_pll_areset_edges", RC);
    expect_v("t1_release_in_window", 1);
    wait_sig(1, 0, 20, n);
    check_v(n);
    wait_sig(0, 0, 40, m);
    check_v(int'(m > 0 && (n + m) >= RC + SS + SC - 1 && (n + m) <= RC + SS + SC + 1));
    expect_v("t1_ready", 1);       check_v(int'(ready));
    expect_v("t1_retry_count", 0); check_v(int'(retry_count));
    expect_v("t1_state_run", 3);   check_v(int'(state_dbg));

    // 4. Lock loss in RUN
    pll_locked = 1'b0;
    expect_v("t4_sys_rst_within", 1);
    wait_sig(0, 1, 10, n);
    check_v(int'(n >= 1 && n <= SS + 1));
    expect_v("t4_pll_areset", 1);  check_v(int'(pll_areset));
    expect_v("t4_state_reset", 0); check_v(int'(state_dbg));
    expect_v("t4_retry_count", 0); check_v(int'(retry_count));
`ifdef PLL_LOSS_COUNTER_EN
    expect_v("t4_loss_count", 1);  check_v(int'(loss_count));
`endif
    pll_locked = 1'b1;
    expect_v("t4_relock_ready", 1);
    wait_sig(4, 1, 60, n);
    check_v(int'(n > 0));

    // 2. Glitchy lock: one low cycle after 5 stable counts
    restart(1'b1);
    edges(8);
    expect_v("t2_stable_before", 2); check_v(int'(state_dbg));
    pll_locked = 1'b0;
    edges(1);
    pll_locked = 1'b1;
    edges(1);
    expect_v("t2_still_stable", 2);  check_v(int'(state_dbg));
    edges(1);
    expect_v("t2_back_to_wait", 1);  check_v(int'(state_dbg));
    expect_v("t2_release_after", 1 + SC);
    wait_sig(0, 0, 40, n);
    check_v(n);
    expect_v("t2_before_timeout", 1); check_v(int'(11 + n < LT + RC));
    expect_v("t2_retry_count", 0);    check_v(int'(retry_count));

    // 5. Asynchronous reset mid-STABLE
    restart(1'b1);
    edges(7);
    expect_v("t5_in_stable", 2); check_v(int'(state_dbg));
    #3;
    areset = 1'b1;
    #1;
    expect_v("t5_async_state", 0);      check_v(int'(state_dbg));
    expect_v("t5_async_pll_areset", 1); check_v(int'(pll_areset));
    expect_v("t5_async_sys_rst", 1);    check_v(int'(sys_rst));
    expect_v("t5_async_ready", 0);      check_v(int'(ready));
    @(negedge inclk0);
    areset = 1'b0;
    expect_v("t5_restart_areset_edges", RC);
    expect_v("t5_restart_release", 1);
    wait_sig(1, 0, 20, n);
    check_v(n);
    wait_sig(0, 0, 40, m);
    check_v(int'(m > 0 && (n + m) >= RC + SS + SC - 1 && (n + m) <= RC + SS + SC + 1));

    // 6a. Stable completes exactly on the timeout cycle
    restart(1'b0);
    edges(25);
    pll_locked = 1'b1;
    edges(10);
    expect_v("t6a_stable_pre", 2); check_v(int'(state_dbg));
    edges(1);
    expect_v("t6a_run", 3);        check_v(int'(state_dbg));
    expect_v("t6a_retry_count", 0); check_v(int'(retry_count));
    expect_v("t6a_ready", 1);      check_v(int'(ready));

    // 6b. One cycle later the timeout wins
    restart(1'b0);
    edges(26);
    pll_locked = 1'b1;
    edges(10);
    expect_v("t6b_state_reset", 0); check_v(int'(state_dbg));
    expect_v("t6b_retry_count", 1); check_v(int'(retry_count));

    // 3. Never locks
    restart(1'b0);
    edges(9);
    retry = 1'b1;
    edges(1);
    retry = 1'b0;
    expect_v("t3_retry_ignored", 1); check_v(int'(state_dbg));
    expect_v("t3_first_timeout_edge", LT + RC - 10);
    wait_sig(3, 1, 60, n);
    check_v(n);
    expect_v("t3_after_first", 0); check_v(int'(state_dbg));
    expect_v("t3_fault_edge", LT + RC);
    wait_sig(2, 4, 80, n);
    check_v(n);
    expect_v("t3_fault", 1);       check_v(int'(fault));
    expect_v("t3_pll_areset", 1);  check_v(int'(pll_areset));
    expect_v("t3_sys_rst", 1);     check_v(int'(sys_rst));
    expect_v("t3_retry_count", 2); check_v(int'(retry_count));
    edges(10);
    expect_v("t3_sticky", 4);      check_v(int'(state_dbg));
    retry = 1'b1;
    edges(1);
    retry = 1'b0;
    expect_v("t3_retry_state", 0); check_v(int'(state_dbg));
    expect_v("t3_retry_rc", 0);    check_v(int'(retry_count));
    expect_v("t3_retry_fault", 0); check_v(int'(fault));
    expect_v("t3_retry_pll_areset", 1); check_v(int'(pll_areset));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the pixel-clock PLL from the 50 MHz reference-clock side.
- Drives the PLL's asynchronous reset and watches its `locked` output.
- Releases a clean downstream reset only after lock has been stable for a set time.
- On lock loss it re-resets the PLL; after too many failed lock attempts it parks in a sticky fault state so the top level can flag it on an LED or status register.

Parameters:
- RESET_CYCLES, 16: cycles `pll_areset` is held high per reset attempt (minimum 1).
- LOCK_TIMEOUT, 50000: cycles allowed per attempt from `pll_areset` release to stable lock (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before release.
- MAX_RETRIES, 3: failed attempts before FAULT (minimum 1).
- SYNC_STAGES, 2: flops in the `pll_locked` synchroniser (minimum 2).

Ports:
- inclk0, input, 1: 50 MHz reference clock. The block runs entirely on this clock.
- areset, input, 1: asynchronous active-high reset.
- pll_locked, input, 1: PLL lock flag. Asynchronous to `inclk0`.
- retry, input, 1: single-cycle pulse. Leaves FAULT only.
- pll_areset, output, 1: registered reset to the PLL.
- sys_rst, output, 1: registered active-high reset for downstream logic.
- ready, output, 1: registered; equals ~`sys_rst`.
- fault, output, 1: registered sticky fault flag.
- retry_count, output, $clog2(MAX_RETRIES+1): failed attempts since the last RUN entry or retry.
- state_dbg, output, 3: current state encoding.

Behaviour:
- Reset (`areset`=1):
  - state=S_RESET; all counters 0; synchroniser cleared.
  - Outputs: `pll_areset`=1, `sys_rst`=1, `ready`=0, `fault`=0.
- Synchroniser: `pll_locked` passes through SYNC_STAGES flops to give `locked_s`. All decisions use `locked_s` only.
- Outputs are registered decodes of the next state, so they change on the same edge as the state:
  - `pll_areset`=1 in S_RESET and S_FAULT.
  - `sys_rst`=1 in every state except S_RUN.
  - `fault`=1 only in S_FAULT.
- S_RESET (0):
  - Counts RESET_CYCLES cycles, then moves to S_WAIT and clears the timeout timer.
- S_WAIT (1):
  - Timeout timer increments every cycle.
  - `locked_s`=1: go to S_STABLE and clear the stable counter.
- S_STABLE (2):
  - Timeout timer keeps running, so a flapping lock cannot extend the attempt.
  - Stable counter increments while `locked_s`=1.
  - `locked_s`=0: back to S_WAIT; the timer is not cleared.
  - Stable counter reaching STABLE_CYCLES-1 with `locked_s`=1: go to S_RUN and clear `retry_count`.
- Timeout, checked in S_WAIT and S_STABLE:
  - When the timer reaches LOCK_TIMEOUT-1 without entering S_RUN, `retry_count` increments.
  - If the new count equals MAX_RETRIES, go to S_FAULT; otherwise go to S_RESET.
  - If the timeout and the stable-complete condition fall on the same cycle, stable-complete wins.
- S_RUN (3):
  - `locked_s`=0: go to S_RESET. `sys_rst` rises on that same edge.
  - This is a lock-loss event; `retry_count` is not incremented.
- S_FAULT (4):
  - Sticky. `retry` pulse: go to S_RESET and clear `retry_count`.
  - `retry` is ignored in every other state.
- Release latency (lock already high at reset release): `sys_rst` falls exactly RESET_CYCLES + SYNC_STAGES + STABLE_CYCLES cycles after the first `inclk0` edge with `areset` low, ±1 cycle.
- Asserting `areset` mid-operation aborts any state immediately and asynchronously.
- Counter widths: each counter is $clog2 of its maximum count. No counter may wrap.

Optional Feature:
- Macro: PLL_LOSS_COUNTER_EN.
- Defined:
  - Extra output `loss_count`, 8 bits, reset 0.
  - Increments on each S_RUN→S_RESET transition and saturates at 255.
  - Cleared only by `areset`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum `pll_seq_state_t` (S_RESET=0, S_WAIT=1, S_STABLE=2, S_RUN=3, S_FAULT=4);
  - width constant STATE_W=3.
- Sub-module sync_bit: parameterised N-stage synchroniser with asynchronous clear, instantiated once for `pll_locked`.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Clean lock: `pll_locked` tied 1 and `areset` released → `pll_areset` high for 4 cycles; `sys_rst` falls at cycle 14±1; `ready`=1; `retry_count`=0.
2. Glitchy lock: `locked` drops for 1 cycle in S_STABLE (after 5 locked cycles) → returns to S_WAIT; the timer is not reset; release occurs only after 8 further consecutive locked cycles and before the 32-cycle timeout.
3. Never locks: `pll_locked`=0 → `retry_count` goes 1 after the first timeout; after the second timeout state=S_FAULT, `fault`=1, `pll_areset`=1, `sys_rst`=1; a `retry` pulse gives S_RESET with `retry_count`=0.
4. Lock loss in RUN: drop `pll_locked` → within SYNC_STAGES+1 cycles `sys_rst`=1 and `pll_areset`=1; with PLL_LOSS_COUNTER_EN, `loss_count`=1; re-lock gives `ready` again.
5. Asynchronous reset mid-S_STABLE: `areset` pulse → outputs return to reset values before the next `inclk0` edge; the sequence restarts from S_RESET.
6. Timeout and stable-complete on the same cycle: align lock so the stable counter completes at timer=31 → S_RUN entered; `retry_count` not incremented.
